// File: rtl/sopc_run_ctrl.sv
// -----------------------------------------------------------------------------
// sopc_run_ctrl
// Run controller for the minimal SOPC. After board reset or a restart it holds
// every reset channel asserted, then releases the channels one at a time
// (channel 0 first). The last release starts the run. During the run it counts
// cycles and watches the core fetch PC. The run ends in one of two ways:
//   - halt (DONE): the PC stays unchanged for HALT_CYCLES valid cycles;
//   - cycle timeout (TIMEOUT): the cycle count reaches TIMEOUT_CYCLES.
//
// Optional feature macro: SOPC_RUN_SNAPSHOT_EN
//   defined   : pc_snap_o captures the last valid PC when the run ends.
//   undefined : pc_snap_o is tied to 0 and no capture register exists.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start_i      restart pulse, honoured only in DONE or TIMEOUT
//   sw_rst_i     software restart, honoured in any state, highest priority
//   pc_i         core fetch PC
//   pc_valid_i   pc_i is valid this cycle
//   core_rst_o   per-channel active-high reset
//   run_o        high while in RUN
//   done_o       sticky, run ended by halt
//   timeout_o    sticky, run ended by timeout
//   cycle_cnt_o  cycles spent in RUN, saturating
//   state_o      00 HOLD, 01 RUN, 10 DONE, 11 TIMEOUT
//   pc_snap_o    PC captured at end of run
// -----------------------------------------------------------------------------
module sopc_run_ctrl #(
    parameter int NUM_RST        = 2,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGGER_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 50,
    parameter int HALT_CYCLES    = 8,
    parameter int PC_W           = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               sw_rst_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               pc_valid_i,
    output logic [NUM_RST-1:0] core_rst_o,
    output logic               run_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [31:0]        cycle_cnt_o,
    output logic [1:0]         state_o,
    output logic [PC_W-1:0]    pc_snap_o
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_e;

    // The run starts on the hold count value that releases the last channel.
    localparam logic [31:0] RUN_AT   = 32'(HOLD_CYCLES + (NUM_RST - 1) * STAGGER_CYCLES);
    localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] HALT_LIM = 32'(HALT_CYCLES);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    state_e             state_q;
    logic [31:0]        hold_cnt_q;
    logic [31:0]        cycle_cnt_q;
    logic [31:0]        stall_cnt_q;
    logic [PC_W-1:0]    last_pc_q;
    logic [NUM_RST-1:0] core_rst_q;
    logic               run_q;
    logic               done_q;
    logic               timeout_q;

    logic [31:0]        hold_cnt_d;
    logic [31:0]        cycle_cnt_d;
    logic [31:0]        stall_cnt_d;
    logic [PC_W-1:0]    last_pc_d;
    logic [NUM_RST-1:0] rel_mask_d;
    logic               restart_d;
    logic               halt_d;
    logic               to_d;

    // Next-value helpers: hold count, channel release mask, halt tracker, run-end events.
    always_comb begin
        hold_cnt_d  = hold_cnt_q + 32'd1;
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        stall_cnt_d = stall_cnt_q;
        last_pc_d   = last_pc_q;
        rel_mask_d  = '0;

        for (int k = 0; k < NUM_RST; k++) begin
            if (hold_cnt_d >= 32'(HOLD_CYCLES + k * STAGGER_CYCLES)) begin
                rel_mask_d[k] = 1'b1;
            end else begin
                rel_mask_d[k] = 1'b0;
            end
        end

        // A new PC restarts the stall count at 1 because that cycle is already
        // the first cycle at the new PC.
        if (pc_valid_i) begin
            if (pc_i == last_pc_q) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = 32'd1;
            end
            last_pc_d = pc_i;
        end else begin
            stall_cnt_d = stall_cnt_q;
            last_pc_d   = last_pc_q;
        end

        restart_d = sw_rst_i ||
                    (start_i && ((state_q == ST_DONE) || (state_q == ST_TIMEOUT)));
        // Halt wins over timeout when both land on the same edge.
        halt_d = (state_q == ST_RUN) && !restart_d && (stall_cnt_d >= HALT_LIM);
        to_d   = (state_q == ST_RUN) && !restart_d && !halt_d &&
                 (TO_LIM != 32'd0) && (cycle_cnt_d >= TO_LIM);
    end

    // Run-control FSM with all status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= 32'd0;
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            last_pc_q   <= '0;
            core_rst_q  <= '1;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (restart_d) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= 32'd0;
            core_rst_q <= '1;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hold_cnt_q <= hold_cnt_d;
                    core_rst_q <= core_rst_q & ~rel_mask_d;
                    if (hold_cnt_d == RUN_AT) begin
                        state_q     <= ST_RUN;
                        run_q       <= 1'b1;
                        cycle_cnt_q <= 32'd0;
                        stall_cnt_q <= 32'd0;
                        last_pc_q   <= '0;
                    end
                end
                ST_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    stall_cnt_q <= stall_cnt_d;
                    last_pc_q   <= last_pc_d;
                    if (halt_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        run_q   <= 1'b0;
                    end else if (to_d) begin
                        state_q    <= ST_TIMEOUT;
                        timeout_q  <= 1'b1;
                        run_q      <= 1'b0;
                        core_rst_q <= '1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q    <= ST_HOLD;
                    hold_cnt_q <= 32'd0;
                    core_rst_q <= '1;
                    run_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SOPC_RUN_SNAPSHOT_EN
    logic [PC_W-1:0] pc_snap_q;

    // End-of-run PC capture; cleared whenever the controller returns to HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_snap_q <= '0;
        end else if (restart_d) begin
            pc_snap_q <= '0;
        end else if (halt_d || to_d) begin
            pc_snap_q <= last_pc_d;
        end else begin
            pc_snap_q <= pc_snap_q;
        end
    end

    assign pc_snap_o = pc_snap_q;
`else
    assign pc_snap_o = '0;
`endif

    assign core_rst_o  = core_rst_q;
    assign run_o       = run_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sopc_run_ctrl
// Directed stimulus for sopc_run_ctrl at default parameters. Each stimulus step
// queues the outputs it expects at given clock edges. A separate monitor checks
// them on the falling edge that follows the named rising edge.
// -----------------------------------------------------------------------------
module tb_sopc_run_ctrl;

    localparam int SEL_CORE  = 0;
    localparam int SEL_RUN   = 1;
    localparam int SEL_DONE  = 2;
    localparam int SEL_TO    = 3;
    localparam int SEL_CNT   = 4;
    localparam int SEL_STATE = 5;
    localparam int SEL_SNAP  = 6;

`ifdef SOPC_RUN_SNAPSHOT_EN
    localparam logic [31:0] SNAP_HALT40 = 32'h0000_0040;
    localparam logic [31:0] SNAP_HALTAC = 32'h0000_00AC;
`else
    localparam logic [31:0] SNAP_HALT40 = 32'h0000_0000;
    localparam logic [31:0] SNAP_HALTAC = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        sw_rst_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic [1:0]  core_rst_o;
    logic        run_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] cycle_cnt_o;
    logic [1:0]  state_o;
    logic [31:0] pc_snap_o;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] act;

    sopc_run_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .sw_rst_i    (sw_rst_i),
        .pc_i        (pc_i),
        .pc_valid_i  (pc_valid_i),
        .core_rst_o  (core_rst_o),
        .run_o       (run_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .cycle_cnt_o (cycle_cnt_o),
        .state_o     (state_o),
        .pc_snap_o   (pc_snap_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dut_field(input int sel);
        case (sel)
            SEL_CORE:  return {30'd0, core_rst_o};
            SEL_RUN:   return {31'd0, run_o};
            SEL_DONE:  return {31'd0, done_o};
            SEL_TO:    return {31'd0, timeout_o};
            SEL_CNT:   return cycle_cnt_o;
            SEL_STATE: return {30'd0, state_o};
            SEL_SNAP:  return pc_snap_o;
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Staggered release after a restart seen at edge s.
    task automatic push_release(input int s, input string tag);
        expect_at(s,      SEL_CORE,  32'd3, {tag, "_rst_all"});
        expect_at(s,      SEL_STATE, 32'd0, {tag, "_state_hold"});
        expect_at(s + 9,  SEL_CORE,  32'd3, {tag, "_pre_rel0"});
        expect_at(s + 10, SEL_CORE,  32'd2, {tag, "_rel0"});
        expect_at(s + 13, SEL_CORE,  32'd2, {tag, "_pre_rel1"});
        expect_at(s + 13, SEL_RUN,   32'd0, {tag, "_pre_run"});
        expect_at(s + 14, SEL_CORE,  32'd0, {tag, "_rel1"});
        expect_at(s + 14, SEL_RUN,   32'd1, {tag, "_run"});
        expect_at(s + 14, SEL_STATE, 32'd1, {tag, "_state_run"});
        expect_at(s + 14, SEL_CNT,   32'd0, {tag, "_cnt_clr"});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation that is due at the current edge.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                act = dut_field(sb_q[i].sel);
                n_tests++;
                if (act !== sb_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s @edge %0d: got %h expected %h",
                             sb_q[i].name, cyc, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, r, s, r2, s2, r3, s3, r4;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        sw_rst_i   = 1'b0;
        pc_i       = 32'd0;
        pc_valid_i = 1'b0;

        // Reset values
        step();
        expect_at(cyc, SEL_CORE,  32'd3, "rst_core");
        expect_at(cyc, SEL_RUN,   32'd0, "rst_run");
        expect_at(cyc, SEL_DONE,  32'd0, "rst_done");
        expect_at(cyc, SEL_TO,    32'd0, "rst_to");
        expect_at(cyc, SEL_CNT,   32'd0, "rst_cnt");
        expect_at(cyc, SEL_STATE, 32'd0, "rst_state");
        expect_at(cyc, SEL_SNAP,  32'd0, "rst_snap");
        step();
        step();
        rst_n = 1'b1;
        e = cyc;
        push_release(e, "boot");
        repeat (14) step();

        n_tests++;
        if (run_o !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_run_direct: got %b expected 1", run_o);
        end
        n_tests++;
        if (core_rst_o !== 2'b00) begin
            n_fail++;
            $display("FAIL boot_core_direct: got %b expected 00", core_rst_o);
        end

        // Timeout run with an incrementing PC; start_i pulse inside RUN is ignored
        r = cyc;
        expect_at(r + 8,  SEL_STATE, 32'd1,  "start_ignored_run");
        expect_at(r + 49, SEL_STATE, 32'd1,  "to_pre_state");
        expect_at(r + 49, SEL_CNT,   32'd49, "to_pre_cnt");
        expect_at(r + 49, SEL_TO,    32'd0,  "to_pre_flag");
        expect_at(r + 50, SEL_TO,    32'd1,  "to_flag");
        expect_at(r + 50, SEL_STATE, 32'd3,  "to_state");
        expect_at(r + 50, SEL_CORE,  32'd3,  "to_core");
        expect_at(r + 50, SEL_RUN,   32'd0,  "to_run");
        expect_at(r + 50, SEL_CNT,   32'd50, "to_cnt");
        expect_at(r + 50, SEL_DONE,  32'd0,  "to_done");
        expect_at(r + 51, SEL_CNT,   32'd50, "to_cnt_frozen");
        for (int k = 0; k < 50; k++) begin
            pc_valid_i = 1'b1;
            pc_i       = 32'(k * 4);
            start_i    = (k == 5);
            step();
        end

        n_tests++;
        if (timeout_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_flag_direct: got %b expected 1", timeout_o);
        end

        pc_valid_i = 1'b0;
        step();

        // Restart out of TIMEOUT
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        s = cyc;
        push_release(s, "restart_to");
        expect_at(s, SEL_TO,  32'd0,  "restart_to_flag_clr");
        expect_at(s, SEL_CNT, 32'd50, "restart_to_cnt_kept");
        repeat (14) step();

        // Halt on constant PC 0x40
        r2 = cyc;
        expect_at(r2 + 7, SEL_STATE, 32'd1, "halt_pre_state");
        expect_at(r2 + 7, SEL_DONE,  32'd0, "halt_pre_done");
        expect_at(r2 + 8, SEL_DONE,  32'd1, "halt_done");
        expect_at(r2 + 8, SEL_STATE, 32'd2, "halt_state");
        expect_at(r2 + 8, SEL_RUN,   32'd0, "halt_run");
        expect_at(r2 + 8, SEL_CORE,  32'd0, "halt_core");
        expect_at(r2 + 8, SEL_CNT,   32'd8, "halt_cnt");
        expect_at(r2 + 8, SEL_SNAP,  SNAP_HALT40, "halt_snap");
        expect_at(r2 + 9, SEL_CNT,   32'd8, "halt_cnt_frozen");
        pc_valid_i = 1'b1;
        pc_i       = 32'h0000_0040;
        repeat (8) step();

        n_tests++;
        if (done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_done_direct: got %b expected 1", done_o);
        end

        pc_valid_i = 1'b0;
        step();

        // Restart out of DONE
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        s2 = cyc;
        push_release(s2, "restart_done");
        expect_at(s2, SEL_DONE, 32'd0, "restart_done_clr");
        expect_at(s2, SEL_SNAP, 32'd0, "restart_snap_clr");
        repeat (14) step();

        // Software reset at run cycle 20
        r3 = cyc;
        expect_at(r3 + 20, SEL_CNT, 32'd20, "swrst_pre_cnt");
        for (int k = 0; k < 20; k++) begin
            pc_valid_i = 1'b1;
            pc_i       = 32'h0000_0100 + 32'(k * 4);
            step();
        end
        sw_rst_i = 1'b1;
        step();
        sw_rst_i   = 1'b0;
        pc_valid_i = 1'b0;
        s3 = cyc;
        push_release(s3, "swrst");
        expect_at(s3, SEL_RUN, 32'd0, "swrst_run");
        repeat (14) step();

        // Halt and timeout landing on the same edge: halt wins
        r4 = cyc;
        expect_at(r4 + 49, SEL_STATE, 32'd1,  "tie_pre_state");
        expect_at(r4 + 50, SEL_DONE,  32'd1,  "tie_done");
        expect_at(r4 + 50, SEL_TO,    32'd0,  "tie_to");
        expect_at(r4 + 50, SEL_STATE, 32'd2,  "tie_state");
        expect_at(r4 + 50, SEL_CORE,  32'd0,  "tie_core");
        expect_at(r4 + 50, SEL_CNT,   32'd50, "tie_cnt");
        expect_at(r4 + 50, SEL_SNAP,  SNAP_HALTAC, "tie_snap");
        for (int i = 1; i <= 50; i++) begin
            pc_valid_i = 1'b1;
            pc_i       = (i <= 43) ? 32'(4 * i) : 32'd172;
            step();
        end
        pc_valid_i = 1'b0;
        repeat (3) step();

        while (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked (due edge %0d, now %0d)",
                     sb_q[0].name, sb_q[0].cyc, cyc);
            void'(sb_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
